// File: rtl/demo_diagnostic_pio_pkg.sv
// Shared constants for the diagnostic PIO: register map, edge-select and IRQ-mode codes.
package demo_diagnostic_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Arm counter saturates here; edges are ignored until it is reached.
    localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/demo_diagnostic_pio_edge.sv
// Pin input path: two-flop synchroniser, delay register, arm counter and edge detector.
module demo_diagnostic_pio_edge
    import demo_diagnostic_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_vec
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] dly_p2;
    logic [1:0]       arm_cnt;
    logic [WIDTH-1:0] raw_edge;

    function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
        return (cnt == ARM_DONE) ? cnt : cnt + 2'd1;
    endfunction

    // Stage p0/p1: metastability synchroniser; stage p2: previous synced value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            dly_p2  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_p0 <= in_port;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
            arm_cnt <= sat_inc(arm_cnt);
        end
    end

    assign in_sync = sync_p1;

    always_comb begin
        raw_edge = sync_p1 & ~dly_p2;
        if (EDGE_TYPE == EDGE_FALL)
            raw_edge = ~sync_p1 & dly_p2;
        else if (EDGE_TYPE == EDGE_ANY)
            raw_edge = sync_p1 ^ dly_p2;
    end

    // Suppress edges while the pipeline still holds reset zeros.
    assign edge_vec = (arm_cnt == ARM_DONE) ? raw_edge : '0;

endmodule

// File: rtl/demo_diagnostic_pio.sv
// Avalon-MM zero-wait-state parallel I/O port with direction, edge capture and IRQ.
module demo_diagnostic_pio
    import demo_diagnostic_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] rd_val;

    assign wr_en = chipselect && !write_n;
    assign wd    = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_wd_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[31:WIDTH];
    end

    demo_diagnostic_pio_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_vec (edge_vec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= '0;
            irqmask  <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out <= wd;
                ADDR_DIR:     dir      <= wd;
                ADDR_IRQMASK: irqmask  <= wd;
                ADDR_OUTSET:  data_out <= data_out | wd;
                ADDR_OUTCLR:  data_out <= data_out & ~wd;
                default:      ;
            endcase
        end
    end

    assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? wd : '0;

    // A new edge overrides a simultaneous W1C so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edgecap <= '0;
        else
            edgecap <= (edgecap & ~edge_clr) | edge_vec;
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = in_sync;
            ADDR_DIR:     rd_val = dir;
            ADDR_IRQMASK: rd_val = irqmask;
            ADDR_EDGECAP: rd_val = edgecap;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out;
    assign oe_port  = dir;
    assign irq      = (IRQ_TYPE == IRQ_LEVEL) ? |(in_sync & irqmask) : |(edgecap & irqmask);

endmodule

// File: tb/tb_demo_diagnostic_pio.sv
// Scoreboard bench: three PIO instances (rising/edge IRQ, rising/level IRQ, any-edge) on shared inputs.
module tb_demo_diagnostic_pio;

    localparam int K_RD_E  = 0;
    localparam int K_OUT_E = 1;
    localparam int K_OE_E  = 2;
    localparam int K_IRQ_E = 3;
    localparam int K_IRQ_L = 4;
    localparam int K_RD_A  = 5;
    localparam int K_IRQ_A = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] rd_e, rd_l, rd_a;
    logic [7:0]  out_e, out_l, out_a;
    logic [7:0]  oe_e, oe_l, oe_a;
    logic        irq_e, irq_l, irq_a;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    demo_diagnostic_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_e (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e), .in_port(in_port),
        .out_port(out_e), .oe_port(oe_e), .irq(irq_e));

    demo_diagnostic_pio #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l), .in_port(in_port),
        .out_port(out_l), .oe_port(oe_l), .irq(irq_l));

    demo_diagnostic_pio #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port),
        .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

    function automatic logic [31:0] pick(input int kind);
        case (kind)
            K_RD_E:  return rd_e;
            K_OUT_E: return {24'd0, out_e};
            K_OE_E:  return {24'd0, oe_e};
            K_IRQ_E: return {31'd0, irq_e};
            K_IRQ_L: return {31'd0, irq_l};
            K_RD_A:  return rd_a;
            default: return {31'd0, irq_a};
        endcase
    endfunction

    // Monitor: drains every expectation queued during the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = pick(e.kind);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] ve, input logic [31:0] va, input string nm);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        expect_sig(K_RD_E, ve, {nm, "_e"});
        expect_sig(K_RD_A, va, {nm, "_a"});
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 8'h00;
        tick();
        tick();
        expect_sig(K_OUT_E, 32'hA5, "rst_out");
        expect_sig(K_OE_E,  32'h00, "rst_oe");
        expect_sig(K_IRQ_E, 32'h0,  "rst_irq_e");
        expect_sig(K_IRQ_L, 32'h0,  "rst_irq_l");
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, 32'h0, "rst_rd");

        // Output register: load, atomic set, atomic clear
        wr(ADDR(0), 32'h3C); expect_sig(K_OUT_E, 32'h3C, "out_data");
        wr(ADDR(4), 32'h81); expect_sig(K_OUT_E, 32'hBD, "out_set");
        wr(ADDR(5), 32'h0C); expect_sig(K_OUT_E, 32'hB1, "out_clr");
        wr(ADDR(1), 32'hF0); expect_sig(K_OE_E, 32'hF0, "oe_dir");
        rd(3'd1, 32'hF0, 32'hF0, "rd_dir");
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        expect_sig(K_OUT_E, 32'hB1, "wr67_ignored");
        rd(3'd6, 32'h0, 32'h0, "rd6");
        rd(3'd4, 32'h0, 32'h0, "rd4");
        rd(3'd5, 32'h0, 32'h0, "rd5");
        wr(3'd1, 32'h1234_560F);
        rd(3'd1, 32'h0F, 32'h0F, "rd_dir_wide");
        wr(3'd2, 32'h01);
        rd(3'd2, 32'h01, 32'h01, "rd_mask");

        // Rising edge on pin0 held two clocks
        in_port = 8'h01;
        tick();
        expect_sig(K_IRQ_E, 32'h0, "irq_e_edge1");
        tick();
        in_port = 8'h00;
        expect_sig(K_IRQ_E, 32'h0, "irq_e_edge2");
        rd(3'd0, 32'h01, 32'h01, "rd_data_sync");
        expect_sig(K_IRQ_E, 32'h1, "irq_e_edge3");
        expect_sig(K_IRQ_A, 32'h1, "irq_a_edge3");
        rd(3'd3, 32'h01, 32'h01, "edgecap_edge3");
        wr(3'd3, 32'h01);
        expect_sig(K_IRQ_E, 32'h0, "irq_e_w1c");
        expect_sig(K_IRQ_A, 32'h1, "irq_a_fall_setwins");
        rd(3'd3, 32'h00, 32'h01, "edgecap_w1c");
        wr(3'd3, 32'h01);
        rd(3'd3, 32'h00, 32'h00, "edgecap_a_clr");

        // Edge lands on the same edge as its W1C
        in_port = 8'h01;
        tick();
        tick();
        wr(3'd3, 32'h01);
        expect_sig(K_IRQ_E, 32'h1, "irq_e_setwins");
        rd(3'd3, 32'h01, 32'h01, "edgecap_setwins");
        in_port = 8'h00;
        repeat (5) tick();
        wr(3'd3, 32'hFF);
        rd(3'd3, 32'h00, 32'h00, "edgecap_cleared");

        // Pins high through reset release must not be captured
        reset_n = 1'b0;
        in_port = 8'hFF;
        tick();
        expect_sig(K_OUT_E, 32'hA5, "rst2_out");
        expect_sig(K_OE_E,  32'h00, "rst2_oe");
        expect_sig(K_IRQ_E, 32'h0,  "rst2_irq_e");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        rd(3'd3, 32'h00, 32'h00, "edgecap_armed");
        rd(3'd0, 32'hFF, 32'hFF, "rd_data_ff");

        // Level-mode IRQ on pin7
        in_port = 8'h00;
        repeat (4) tick();
        wr(3'd2, 32'h80);
        in_port = 8'h80;
        expect_sig(K_IRQ_L, 32'h0, "lvl_edge0");
        tick();
        expect_sig(K_IRQ_L, 32'h0, "lvl_edge1");
        tick();
        expect_sig(K_IRQ_L, 32'h1, "lvl_edge2");
        in_port = 8'h00;
        tick();
        expect_sig(K_IRQ_L, 32'h1, "lvl_drop1");
        expect_sig(K_IRQ_E, 32'h1, "irq_e_bit7");
        tick();
        expect_sig(K_IRQ_L, 32'h0, "lvl_drop2");
        tick();
        tick();

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [2:0] ADDR(input int a);
        return 3'(a);
    endfunction

endmodule
